// File: rtl/config_loader.sv
// Serialises bitstream words (bit 0 first) onto the config chain, asserting config_en for exactly CHAIN_LENGTH shifts.
// A word accepted at cycle a shifts during a+1..a+WORD_WIDTH; word_ready is high only in WAIT_WORD, so upstream stalls by holding word_valid low.
module config_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 16,
  parameter int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
  input  logic                  config_clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_out,
  output logic                  config_en,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  bits_loaded
);

  localparam int WB_WIDTH = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [WORD_WIDTH-1:0] shreg;
  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic [WB_WIDTH-1:0]   word_bit;
  logic                  last_bit;
  logic                  word_end;

  assign last_bit = (bit_cnt == CNT_WIDTH'(CHAIN_LENGTH - 1));
  assign word_end = (word_bit == WB_WIDTH'(WORD_WIDTH - 1));

  always_ff @(posedge config_clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Chain-length check wins over word end, which is how a partial last word is truncated.
  always_comb begin
    state_nxt = state;
    if (state != IDLE && abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (start) state_nxt = WAIT_WORD;
        WAIT_WORD: if (word_valid) state_nxt = SHIFT;
        SHIFT: begin
          if (last_bit) begin
            state_nxt = DONE;
          end else if (word_end) begin
            state_nxt = WAIT_WORD;
          end
        end
        DONE:      state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // The shift still counts on an aborting cycle so bits_loaded reflects every bit that left.
  always_ff @(posedge config_clk or negedge resetn) begin
    if (!resetn) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      word_bit <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) bit_cnt <= '0;
        end
        WAIT_WORD: begin
          if (word_valid && !abort) begin
            shreg    <= word_data;
            word_bit <= '0;
          end
        end
        SHIFT: begin
          shreg    <= shreg >> 1;
          bit_cnt  <= bit_cnt + CNT_WIDTH'(1);
          word_bit <= word_bit + WB_WIDTH'(1);
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    word_ready  = (state == WAIT_WORD);
    config_en   = (state == SHIFT);
    config_out  = (state == SHIFT) & shreg[0];
    busy        = (state != IDLE);
    done        = (state == DONE);
    bits_loaded = bit_cnt;
  end

endmodule
